two_bit_down_counter: RTL
=========================

TWO_BIT_DOWN_COUNTER -- requirements
Module: two_bit_down_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the count width in bits; the minimum legal value is 2.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst_n, input, 1 bit, SHALL be the reset: synchronous and active-low.
REQ-004 Port load_valid, input, 1 bit, SHALL request loading of load_val.
REQ-005 Port load_val, input, WIDTH bits, SHALL be the start value, sampled when a load is accepted.
REQ-006 Port load_ready, output, 1 bit, SHALL indicate that the block accepts a load in the current cycle.
REQ-007 Port step, input, 1 bit, SHALL request a decrement by 1 in the current cycle.
REQ-008 Port count, output, WIDTH bits, SHALL be the registered current value.
REQ-009 Port busy, output, 1 bit, SHALL be high while in state RUN.
REQ-010 Port done, output, 1 bit, SHALL be a registered one-cycle pulse on reaching zero.
REQ-011 Port borrow, output, 1 bit, SHALL be a registered one-cycle pulse on a step taken at zero.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and EMPTY.
REQ-013 load_ready SHALL be 1 in IDLE and EMPTY and 0 in RUN; it is combinational from state only.
REQ-014 A load is accepted when load_valid and load_ready are both 1; on the next edge count SHALL equal load_val (1-cycle latency).
REQ-015 After an accepted load, the next state SHALL be EMPTY if load_val is 0, otherwise RUN; no done pulse is produced for a zero load.
REQ-016 In RUN with step=1, count SHALL become count-1 on the next edge; with step=0, count SHALL hold.
REQ-017 In RUN with count=1 and step=1, the block SHALL go to EMPTY with count=0, and done SHALL be 1 for exactly the following cycle.
REQ-018 In IDLE, step SHALL be ignored: count holds and no pulses are produced.
REQ-019 In EMPTY with step=1 and no accepted load, borrow SHALL be 1 for exactly the following cycle; the count update is defined by REQ-026/REQ-027.
REQ-020 In EMPTY, if a load is accepted and step=1 in the same cycle, the load SHALL win: no borrow and no decrement.
REQ-021 load_valid in RUN SHALL be ignored; the requester holds load_valid until load_ready is 1.
REQ-022 All arithmetic SHALL be modulo 2^WIDTH, and done and borrow SHALL never both be 1 in the same cycle.

Reset
REQ-023 rst_n=0 at a clock edge SHALL force state IDLE, count=0, done=0 and borrow=0, overriding load and step in that cycle, including mid-count in RUN.
REQ-024 In the cycle after reset release, load_ready SHALL be 1 and busy SHALL be 0.

Configuration
REQ-025 The macro DOWN_COUNTER_WRAP_EN SHALL select underflow behaviour.
REQ-026 With DOWN_COUNTER_WRAP_EN defined, a step in EMPTY SHALL set count to 2^WIDTH-1, pulse borrow and move to RUN.
REQ-027 Without DOWN_COUNTER_WRAP_EN, a step in EMPTY SHALL hold count at 0, pulse borrow and remain in EMPTY.

Verification
REQ-028 Reset then load 3 with step held at 1 -> count sequence 3,2,1,0; done is 1 for one cycle immediately after count reaches 0; busy falls in the same cycle.
REQ-029 Load 2, step pattern 1,0,1 -> count sequence 2,1,1,0; load_valid asserted in RUN is ignored and load_ready stays 0.
REQ-030 From EMPTY, step=1 -> borrow is a one-cycle pulse; count becomes 3 (WRAP_EN, WIDTH=2) or stays 0 (without WRAP_EN).
REQ-031 In EMPTY, load_valid=1 with load_val=2 and step=1 in the same cycle -> count=2, state RUN, borrow=0.
REQ-032 Load 3, one step, then rst_n=0 for one edge -> count=0, state IDLE, done=0 and borrow=0.
REQ-033 Load 0 -> state EMPTY directly, count=0, done stays 0.

Source files
------------

// File: rtl/two_bit_down_counter.sv
// Loadable down counter with a three-state FSM (IDLE / RUN / EMPTY).
// Define DOWN_COUNTER_WRAP_EN to make a step in EMPTY wrap to all-ones and resume RUN.
module two_bit_down_counter #(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_val,
   output logic             load_ready,
   input  logic             step,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             borrow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      EMPTY = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic             r_done;
   logic             r_borrow;
   logic             w_load;

   assign load_ready = (r_state != RUN);
   assign busy       = (r_state == RUN);
   assign w_load     = load_valid && load_ready;
   assign count      = r_count;
   assign done       = r_done;
   assign borrow     = r_borrow;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_done   <= 1'b0;
         r_borrow <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_borrow <= 1'b0;
         // A load always wins over a step in the same cycle; RUN never accepts one.
         if (w_load) begin
            r_count <= load_val;
            r_state <= (load_val == '0) ? EMPTY : RUN;
         end else begin
            case (r_state)
               RUN: begin
                  if (step) begin
                     r_count <= r_count - 1'b1;
                     if (r_count == WIDTH'(1)) begin
                        r_state <= EMPTY;
                        r_done  <= 1'b1;
                     end
                  end
               end
               EMPTY: begin
                  if (step) begin
                     r_borrow <= 1'b1;
`ifdef DOWN_COUNTER_WRAP_EN
                     r_count  <= '1;
                     r_state  <= RUN;
`else
                     r_count  <= '0;
`endif
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
